// File: rtl/crc4_tx_framer.sv
// Transmit framer: latches one 64-bit payload plus addresses, computes its CRC-4 (x^4+x+1)
// bit-serially, then holds the frame until downstream accepts it. Optional: CRC_ERR_INJECT_EN.
module crc4_tx_framer #(
    parameter int unsigned BITS_PER_CYCLE = 1,
    parameter logic [3:0]  CRC_INIT       = 4'h0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        inValid,
    output logic        inReady,
    input  logic [63:0] inData,
    input  logic [3:0]  inSender,
    input  logic [3:0]  inReceiver,
    output logic        outValid,
    input  logic        outReady,
    output logic [63:0] outData,
    output logic [3:0]  outCRC,
    output logic [3:0]  outSender,
    output logic [3:0]  outReceiver
`ifdef CRC_ERR_INJECT_EN
    ,
    input  logic        errInject
`endif
);

    localparam int unsigned N     = 64 / BITS_PER_CYCLE;
    localparam int unsigned CNT_W = $clog2(N) + 1;

    generate
        if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4 ||
              BITS_PER_CYCLE == 8 || BITS_PER_CYCLE == 16)) begin : g_bad_bpc
            $error("crc4_tx_framer: BITS_PER_CYCLE must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [63:0]        shift_q, shift_d;
    logic [63:0]        data_q, data_d;
    logic [3:0]         crc_q, crc_d;
    logic [3:0]         sender_q, sender_d;
    logic [3:0]         receiver_q, receiver_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         crc_next;

`ifdef CRC_ERR_INJECT_EN
    logic err_q, err_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`else
    logic err_q;
    assign err_q = 1'b0;
`endif

    // MSB-first serial division; feedback taps x^1 and x^0 of the polynomial.
    function automatic logic [3:0] crc_step(input logic [3:0] c,
                                            input logic [BITS_PER_CYCLE-1:0] bits);
        logic [3:0]                r;
        logic [BITS_PER_CYCLE-1:0] b;
        logic                      fb;
        r = c;
        b = bits;
        for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
            fb = r[3] ^ b[BITS_PER_CYCLE-1];
            r  = {r[2:0], 1'b0} ^ (fb ? 4'h3 : 4'h0);
            b  = b << 1;
        end
        return r;
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            data_q     <= '0;
            crc_q      <= '0;
            sender_q   <= '0;
            receiver_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            crc_q      <= crc_d;
            sender_q   <= sender_d;
            receiver_q <= receiver_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        data_d     = data_q;
        crc_d      = crc_q;
        sender_d   = sender_q;
        receiver_d = receiver_q;
        cnt_d      = cnt_q;
        inReady    = 1'b0;
        outValid   = 1'b0;
        crc_next   = crc_step(crc_q, shift_q[63 -: BITS_PER_CYCLE]);
`ifdef CRC_ERR_INJECT_EN
        err_d      = err_q;
`endif

        case (state_q)
            IDLE: begin
                inReady = 1'b1;
                if (inValid) begin
                    shift_d    = inData;
                    data_d     = inData;
                    sender_d   = inSender;
                    receiver_d = inReceiver;
                    crc_d      = CRC_INIT;
                    cnt_d      = '0;
`ifdef CRC_ERR_INJECT_EN
                    err_d      = errInject;
`endif
                    state_d    = CALC;
                end
            end
            CALC: begin
                crc_d   = crc_next;
                shift_d = shift_q << BITS_PER_CYCLE;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N - 1)) begin
                    // Corruption (if requested) is applied once, as the final CRC is captured.
                    crc_d   = crc_next ^ {3'b000, err_q};
                    state_d = HOLD;
                end
            end
            HOLD: begin
                outValid = 1'b1;
                if (outReady) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign outData     = data_q;
    assign outCRC      = crc_q;
    assign outSender   = sender_q;
    assign outReceiver = receiver_q;

endmodule

// File: tb/tb_crc4_tx_framer.sv
// Directed bench for crc4_tx_framer: one instance per legal BITS_PER_CYCLE sharing clock,
// reset and payload inputs, with per-instance handshakes and hand-computed CRCs.
module tb_crc4_tx_framer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [4:0]  inValid, inReady, outValid, outReady;
    logic [63:0] inData;
    logic [3:0]  inSender, inReceiver;
    logic [63:0] outData     [5];
    logic [3:0]  outCRC      [5];
    logic [3:0]  outSender   [5];
    logic [3:0]  outReceiver [5];
`ifdef CRC_ERR_INJECT_EN
    logic        errInject;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    generate
        for (genvar g = 0; g < 5; g++) begin : g_dut
            crc4_tx_framer #(
                .BITS_PER_CYCLE(1 << g),
                .CRC_INIT      (4'h0)
            ) u_dut (
                .clock      (clock),
                .reset_n    (reset_n),
                .inValid    (inValid[g]),
                .inReady    (inReady[g]),
                .inData     (inData),
                .inSender   (inSender),
                .inReceiver (inReceiver),
                .outValid   (outValid[g]),
                .outReady   (outReady[g]),
                .outData    (outData[g]),
                .outCRC     (outCRC[g]),
                .outSender  (outSender[g]),
                .outReceiver(outReceiver[g])
`ifdef CRC_ERR_INJECT_EN
                ,
                .errInject  (errInject)
`endif
            );
        end
    endgenerate

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Offer one payload to instance idx, measure latency, check the frame, then hand it off.
    task automatic run_frame(input int idx, input logic [63:0] d, input logic [3:0] s,
                             input logic [3:0] r, input logic [3:0] exp_crc, input int exp_lat);
        int lat;
        @(negedge clock);
        inData        = d;
        inSender      = s;
        inReceiver    = r;
        inValid[idx]  = 1'b1;
        check_eq("inReady_idle", 64'(inReady[idx]), 64'd1);
        @(negedge clock);
        inValid[idx]  = 1'b0;
        inData        = '1;
        inSender      = '1;
        inReceiver    = '1;
        check_eq("inReady_calc", 64'(inReady[idx]), 64'd0);
        lat = 0;
        while (!outValid[idx] && lat < 200) begin
            @(negedge clock);
            lat++;
        end
        check_eq("latency", 64'(lat), 64'(exp_lat));
        check_eq("outCRC", 64'(outCRC[idx]), 64'(exp_crc));
        check_eq("outData", outData[idx], d);
        check_eq("outSender", 64'(outSender[idx]), 64'(s));
        check_eq("outReceiver", 64'(outReceiver[idx]), 64'(r));
        outReady[idx] = 1'b1;
        @(negedge clock);
        outReady[idx] = 1'b0;
        check_eq("outValid_after_hs", 64'(outValid[idx]), 64'd0);
        check_eq("inReady_after_hs", 64'(inReady[idx]), 64'd1);
    endtask

    initial begin
        int lat;
        reset_n    = 1'b0;
        inValid    = '0;
        outReady   = '0;
        inData     = '0;
        inSender   = '0;
        inReceiver = '0;
`ifdef CRC_ERR_INJECT_EN
        errInject  = 1'b0;
`endif

        repeat (3) @(negedge clock);
        check_eq("rst_outValid", 64'(outValid), 64'd0);
        check_eq("rst_outData", outData[0], 64'd0);
        check_eq("rst_outCRC", 64'(outCRC[0]), 64'd0);
        reset_n = 1'b1;
        @(negedge clock);
        check_eq("rst_inReady", 64'(inReady), 64'h1f);

        // BITS_PER_CYCLE = 1
        run_frame(0, 64'h0000_0000_0000_0001, 4'h2, 4'h9, 4'h3, 64);
        run_frame(0, 64'h8000_0000_0000_0000, 4'h1, 4'h7, 4'hB, 64);
        run_frame(0, 64'h0000_0000_0000_0010, 4'hA, 4'h5, 4'h5, 64);
        run_frame(0, 64'h0000_0000_0000_0000, 4'hF, 4'h0, 4'h0, 64);

        // Wider folds must give identical CRCs with shorter latency.
        for (int i = 1; i < 5; i++) begin
            run_frame(i, 64'h0000_0000_0000_0001, 4'h2, 4'h9, 4'h3, 64 >> i);
            run_frame(i, 64'h8000_0000_0000_0000, 4'h3, 4'hC, 4'hB, 64 >> i);
            run_frame(i, 64'h0000_0000_0000_0010, 4'h6, 4'h1, 4'h5, 64 >> i);
        end

        // Backpressure: hold in HOLD while a second payload is offered.
        @(negedge clock);
        inData = 64'h1; inSender = 4'h2; inReceiver = 4'h9; inValid[0] = 1'b1;
        @(negedge clock);
        inValid[0] = 1'b0;
        lat = 0;
        while (!outValid[0] && lat < 200) begin
            @(negedge clock);
            lat++;
        end
        check_eq("bp_latency", 64'(lat), 64'd64);
        inData = 64'h10; inSender = 4'h4; inReceiver = 4'h8; inValid[0] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            check_eq("bp_outValid", 64'(outValid[0]), 64'd1);
            check_eq("bp_inReady", 64'(inReady[0]), 64'd0);
            check_eq("bp_outData", outData[0], 64'h1);
            check_eq("bp_outCRC", 64'(outCRC[0]), 64'h3);
            check_eq("bp_outSender", 64'(outSender[0]), 64'h2);
        end
        outReady[0] = 1'b1;
        @(negedge clock);
        outReady[0] = 1'b0;
        check_eq("bp_hs_outValid", 64'(outValid[0]), 64'd0);
        check_eq("bp_hs_inReady", 64'(inReady[0]), 64'd1);
        @(negedge clock);
        inValid[0] = 1'b0;
        check_eq("bp_second_taken", 64'(inReady[0]), 64'd0);
        check_eq("bp_second_data", outData[0], 64'h10);
        lat = 0;
        while (!outValid[0] && lat < 200) begin
            @(negedge clock);
            lat++;
        end
        check_eq("bp2_latency", 64'(lat), 64'd64);
        check_eq("bp2_outCRC", 64'(outCRC[0]), 64'h5);
        check_eq("bp2_outReceiver", 64'(outReceiver[0]), 64'h8);
        outReady[0] = 1'b1;
        @(negedge clock);
        outReady[0] = 1'b0;

        // Asynchronous reset 30 cycles into CALC.
        @(negedge clock);
        inData = 64'h1; inSender = 4'h5; inReceiver = 4'h6; inValid[0] = 1'b1;
        @(negedge clock);
        inValid[0] = 1'b0;
        repeat (30) @(negedge clock);
        check_eq("mid_calc_outValid", 64'(outValid[0]), 64'd0);
        check_eq("mid_calc_outData", outData[0], 64'h1);
        #2 reset_n = 1'b0;
        #1;
        check_eq("arst_outValid", 64'(outValid[0]), 64'd0);
        check_eq("arst_outData", outData[0], 64'd0);
        check_eq("arst_outCRC", 64'(outCRC[0]), 64'd0);
        check_eq("arst_outSender", 64'(outSender[0]), 64'd0);
        check_eq("arst_outReceiver", 64'(outReceiver[0]), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check_eq("arst_inReady", 64'(inReady[0]), 64'd1);
        run_frame(0, 64'h8000_0000_0000_0000, 4'h3, 4'h4, 4'hB, 64);

`ifdef CRC_ERR_INJECT_EN
        errInject = 1'b1;
        run_frame(3, 64'h1, 4'h2, 4'h9, 4'h2, 8);
        errInject = 1'b0;
        run_frame(3, 64'h1, 4'h2, 4'h9, 4'h3, 8);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/crc4_tx_framer.md
Name: crc4_tx_framer

Overview:
- Upstream stage of the 16-node CRC-checked routing fabric.
- Accepts one 64-bit payload plus sender/receiver addresses per transaction and computes its 4-bit CRC bit-serially.
- Presents the payload, CRC and addresses as one frame, directly consumable on a node's Data/CRC/senderAddress/receiverAddress inputs.
- One instance per transmitting node.

Parameters:
- BITS_PER_CYCLE, 1, payload bits folded into the CRC per clock; legal values 1, 2, 4, 8, 16; other values are a compile-time error.
- CRC_INIT, 4'h0, CRC register value loaded at frame start.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- inValid  input  1  upstream offers a payload.
- inReady  output  1  framer can accept a payload.
- inData  input  64  payload.
- inSender  input  4  sender node address.
- inReceiver  input  4  receiver node address.
- outValid  output  1  frame available.
- outReady  input  1  downstream accepts the frame.
- outData  output  64  registered payload.
- outCRC  output  4  computed CRC.
- outSender  output  4  registered sender address.
- outReceiver  output  4  registered receiver address.

Behaviour:
- CRC definition: polynomial x^4+x+1 (0x3), no reflection, no final XOR. Payload is processed MSB (bit 63) first and equals the remainder of M(x)*x^4 mod g(x) when CRC_INIT=0.
- Consequence: a receiver running the same CRC over payload followed by outCRC obtains remainder 0.
- States: IDLE, CALC, HOLD.
- IDLE:
  - inReady=1.
  - On inValid&&inReady: latch inData into a shift register and into outData; latch inSender and inReceiver.
  - Load CRC with CRC_INIT and clear the bit counter; go to CALC.
- CALC:
  - inReady=0, outValid=0.
  - Each cycle, fold the top BITS_PER_CYCLE bits of the shift register into the CRC, shift left by BITS_PER_CYCLE, and increment the counter.
  - After N=64/BITS_PER_CYCLE cycles, go to HOLD.
- HOLD:
  - outValid=1. outData, outCRC, outSender and outReceiver are stable and unchanged until the handshake.
  - On outValid&&outReady, go to IDLE.
  - Inputs are ignored while in HOLD.
- Latency: outValid rises N clock edges after the accepting edge (64 for BITS_PER_CYCLE=1, 8 for BITS_PER_CYCLE=8).
- Throughput: one frame per N+2 cycles at best; transactions never overlap.
- outReady held low: stay in HOLD indefinitely with outputs frozen.
- inValid asserted during CALC or HOLD: not accepted. Upstream must hold inValid and its data until inReady=1.
- inValid dropped before acceptance: no effect.
- Counter width is ceil(log2(N))+1. No wrap: the transition to HOLD occurs exactly when the counter reaches N-1 on an active CALC cycle.
- Reset, including mid-CALC or mid-HOLD:
  - Immediately go to IDLE and discard the frame in flight.
  - outValid=0, inReady=1 once reset_n is high.
  - outData=0, outCRC=0, outSender=0, outReceiver=0.
  - Shift register, CRC register and counter are cleared.

Optional Feature:
- CRC_ERR_INJECT_EN defined:
  - Adds input port errInject (1 bit), sampled only on the accepting handshake.
  - If it was 1, outCRC bit 0 is inverted when HOLD is entered, deliberately corrupting the frame for receiver-side CRC-check testing.
  - All other fields are unaffected.
- CRC_ERR_INJECT_EN undefined: the port does not exist and outCRC is always the true CRC.

Test Plan:
- Reset, then BITS_PER_CYCLE=1, inData=64'h0000_0000_0000_0001, inSender=4'h2, inReceiver=4'h9 -> after 64 cycles outValid=1, outCRC=4'h3, outSender=2, outReceiver=9, outData unchanged.
- inData=64'h8000_0000_0000_0000 -> outCRC=4'hB.
- inData=64'h10 -> outCRC=4'h5.
- inData=0 -> outCRC=4'h0.
- Repeat the first three payloads at BITS_PER_CYCLE=2, 4, 8 and 16 -> identical CRCs; latency is 32, 16, 8 and 4 cycles respectively.
- Backpressure: outReady=0 for 20 cycles in HOLD while a new inValid is offered -> outputs frozen, inReady=0, second payload not taken. Raise outReady -> exactly one handshake, return to IDLE, second payload accepted the next cycle.
- Assert reset_n low at cycle 30 of CALC -> outValid=0 and all outputs 0 asynchronously. After release, inReady=1 and a new frame produces the correct CRC.
- With CRC_ERR_INJECT_EN defined: inData=64'h1 with errInject=1 -> outCRC=4'h2. Same payload with errInject=0 -> outCRC=4'h3.
